// File: rtl/dma_slot_arbiter_pkg.sv
// Shared owner encoding and fixed-slot boundaries for the chip-bus DMA slot arbiter.
package dma_slot_arbiter_pkg;

  typedef enum logic [3:0] {
    OWN_IDLE = 4'd0,
    OWN_REF  = 4'd1,
    OWN_DSK  = 4'd2,
    OWN_AUD  = 4'd3,
    OWN_SPR  = 4'd4,
    OWN_BPL  = 4'd5,
    OWN_COP  = 4'd6,
    OWN_BLT  = 4'd7,
    OWN_CPU  = 4'd8
  } owner_e;

  typedef enum logic [2:0] {
    SC_POOL,
    SC_REF,
    SC_DSK,
    SC_AUD,
    SC_SPR
  } slot_class_e;

  // Fixed slots are odd slot numbers within these inclusive ranges.
  localparam logic [7:0] REF_FIRST     = 8'h01;
  localparam logic [7:0] REF_LAST      = 8'h07;
  localparam logic [7:0] DSK_FIRST     = 8'h09;
  localparam logic [7:0] DSK_LAST      = 8'h0D;
  localparam logic [7:0] AUD_FIRST     = 8'h0F;
  localparam logic [7:0] AUD_LAST      = 8'h15;
  localparam logic [7:0] SPR_FIRST_DEF = 8'h17;
  localparam logic [7:0] SPR_SPAN      = 8'h1E;
  localparam int         BLT_NICE_DEF  = 3;

endpackage

// File: rtl/dma_slot_arbiter_if.sv
// Beam position, DMA requests and registered slot grants between the beam counter side and the arbiter.
interface dma_slot_arbiter_if;
  logic       cck;
  logic [7:0] hpos;
  logic [7:0] htotal;
  logic       req_dsk;
  logic [3:0] req_aud;
  logic [7:0] req_spr;
  logic       req_bpl;
  logic       req_cop;
  logic       req_blt;
  logic       req_cpu;
  logic       blt_nasty;
  logic       gnt_ref;
  logic       gnt_dsk;
  logic [3:0] gnt_aud;
  logic [7:0] gnt_spr;
  logic       gnt_bpl;
  logic       gnt_cop;
  logic       gnt_blt;
  logic       gnt_cpu;
  logic [3:0] owner;

  modport master (
    output cck, hpos, htotal, req_dsk, req_aud, req_spr, req_bpl, req_cop, req_blt, req_cpu, blt_nasty,
    input  gnt_ref, gnt_dsk, gnt_aud, gnt_spr, gnt_bpl, gnt_cop, gnt_blt, gnt_cpu, owner
  );

  modport slave (
    input  cck, hpos, htotal, req_dsk, req_aud, req_spr, req_bpl, req_cop, req_blt, req_cpu, blt_nasty,
    output gnt_ref, gnt_dsk, gnt_aud, gnt_spr, gnt_bpl, gnt_cop, gnt_blt, gnt_cpu, owner
  );
endinterface

// File: rtl/dma_slot_arbiter_slot_decoder.sv
// Combinational slot number -> fixed slot class and channel index (audio channel or sprite number).
module dma_slot_arbiter_slot_decoder
  import dma_slot_arbiter_pkg::*;
#(
  parameter logic [7:0] SPR_FIRST = SPR_FIRST_DEF
) (
  input  logic [7:0]  ns,
  output slot_class_e cls,
  output logic [2:0]  ch
);

  always_comb begin
    cls = SC_POOL;
    ch  = 3'd0;
    // Every fixed slot is odd; even slots always belong to the pool.
    if (ns[0]) begin
      if (ns >= REF_FIRST && ns <= REF_LAST) begin
        cls = SC_REF;
      end else if (ns >= DSK_FIRST && ns <= DSK_LAST) begin
        cls = SC_DSK;
      end else if (ns >= AUD_FIRST && ns <= AUD_LAST) begin
        cls = SC_AUD;
        ch  = 3'((ns - AUD_FIRST) >> 1);
      end else if (ns >= SPR_FIRST && ns <= SPR_FIRST + SPR_SPAN) begin
        cls = SC_SPR;
        ch  = 3'((ns - SPR_FIRST) >> 2);
      end
    end
  end

endmodule

// File: rtl/dma_slot_arbiter.sv
// Hands each CCK slot to one DMA owner: fixed slots first, then bpl > cop > blt > cpu in the pool.
// Decided on cck==1 edges, grant held for the whole next slot; no backpressure, a request simply waits.
module dma_slot_arbiter
  import dma_slot_arbiter_pkg::*;
#(
  parameter logic [7:0] SPR_FIRST = SPR_FIRST_DEF,
  parameter int         BLT_NICE  = BLT_NICE_DEF
) (
  input logic clk,
  input logic reset,
  dma_slot_arbiter_if.slave bus
);

  localparam int CW = (BLT_NICE < 2) ? 1 : $clog2(BLT_NICE + 1);

  logic [7:0]    ns;
  slot_class_e   cls;
  logic [2:0]    ch;
  owner_e        own_d;
  owner_e        own_q;
  logic [2:0]    ch_q;
  logic [CW-1:0] starve_d;
  logic [CW-1:0] starve_q;
  logic          starved;

  // A beam position past htotal (after a VHPOSW write) also restarts the line.
  assign ns = (bus.hpos >= bus.htotal) ? 8'd0 : bus.hpos + 8'd1;

  dma_slot_arbiter_slot_decoder #(
    .SPR_FIRST (SPR_FIRST)
  ) u_slot_decoder (
    .ns  (ns),
    .cls (cls),
    .ch  (ch)
  );

  assign starved = !bus.blt_nasty && (starve_q == CW'(BLT_NICE));

  always_comb begin
    own_d = OWN_IDLE;
    unique case (cls)
      SC_REF:  own_d = OWN_REF;
      SC_DSK:  if (bus.req_dsk)          own_d = OWN_DSK;
      SC_AUD:  if (bus.req_aud[ch[1:0]]) own_d = OWN_AUD;
      SC_SPR:  if (bus.req_spr[ch])      own_d = OWN_SPR;
      default: own_d = OWN_IDLE;
    endcase
    // Unclaimed disk/audio/sprite slots fall through to the shared pool.
    if (cls != SC_REF && own_d == OWN_IDLE) begin
      if (bus.req_bpl)                  own_d = OWN_BPL;
      else if (bus.req_cop && !ns[0])   own_d = OWN_COP;
      else if (starved && bus.req_cpu)  own_d = OWN_CPU;
      else if (bus.req_blt)             own_d = OWN_BLT;
      else if (bus.req_cpu)             own_d = OWN_CPU;
    end
  end

  always_comb begin
    if (bus.blt_nasty || !bus.req_cpu || own_d == OWN_CPU) begin
      starve_d = '0;
    end else if (own_d == OWN_BLT && !starved) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q    <= OWN_IDLE;
      ch_q     <= 3'd0;
      starve_q <= '0;
    end else if (bus.cck) begin
      own_q    <= own_d;
      ch_q     <= ch;
      starve_q <= starve_d;
    end
  end

  // Grants are decoded from the registered owner so they stay mutually exclusive.
  assign bus.gnt_ref = (own_q == OWN_REF);
  assign bus.gnt_dsk = (own_q == OWN_DSK);
  assign bus.gnt_aud = (own_q == OWN_AUD) ? (4'b0001 << ch_q[1:0]) : 4'b0000;
  assign bus.gnt_spr = (own_q == OWN_SPR) ? (8'b0000_0001 << ch_q) : 8'b0000_0000;
  assign bus.gnt_bpl = (own_q == OWN_BPL);
  assign bus.gnt_cop = (own_q == OWN_COP);
  assign bus.gnt_blt = (own_q == OWN_BLT);
  assign bus.gnt_cpu = (own_q == OWN_CPU);
  assign bus.owner   = own_q;

endmodule

// File: tb/tb_dma_slot_arbiter.sv
// Self-checking bench for dma_slot_arbiter: vector table, corner sequences, random vs. reference model.
module tb_dma_slot_arbiter;
  import dma_slot_arbiter_pkg::*;

  typedef struct packed {
    logic       dsk;
    logic [3:0] aud;
    logic [7:0] spr;
    logic       bpl;
    logic       cop;
    logic       blt;
    logic       cpu;
    logic       nasty;
  } req_t;

  typedef struct {
    logic [7:0] hp;
    logic [7:0] ht;
    req_t       r;
    logic [3:0] own;
    logic [2:0] idx;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [17:0] gv;
  logic [17:0] exp_vec_q;
  int          checks;
  int          failures;
  int          m_cnt;
  vec_t        tbl[19];

  dma_slot_arbiter_if bus();

  dma_slot_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign gv = {bus.gnt_ref, bus.gnt_dsk, bus.gnt_aud, bus.gnt_spr,
               bus.gnt_bpl, bus.gnt_cop, bus.gnt_blt, bus.gnt_cpu};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic req_t mkreq(input logic dsk, input logic [3:0] aud, input logic [7:0] spr,
                                 input logic bpl, input logic cop, input logic blt,
                                 input logic cpu, input logic nasty);
    req_t r;
    r = '{dsk: dsk, aud: aud, spr: spr, bpl: bpl, cop: cop, blt: blt, cpu: cpu, nasty: nasty};
    return r;
  endfunction

  // One bit per grant in the order of gv.
  function automatic logic [17:0] mk_vec(input logic [3:0] own, input logic [2:0] idx);
    logic [17:0] v;
    logic [3:0]  a;
    logic [7:0]  s;
    v = '0;
    a = 4'b0001 << idx[1:0];
    s = 8'b0000_0001 << idx;
    case (own)
      OWN_REF: v[17]    = 1'b1;
      OWN_DSK: v[16]    = 1'b1;
      OWN_AUD: v[15:12] = a;
      OWN_SPR: v[11:4]  = s;
      OWN_BPL: v[3]     = 1'b1;
      OWN_COP: v[2]     = 1'b1;
      OWN_BLT: v[1]     = 1'b1;
      OWN_CPU: v[0]     = 1'b1;
      default: v        = '0;
    endcase
    return v;
  endfunction

  // Reference: slot map by plain arithmetic on the slot number, then pool priority.
  function automatic logic [6:0] model(input logic [7:0] hp, input logic [7:0] ht,
                                       input req_t r, input int cnt);
    int         ns;
    logic [3:0] own;
    logic [2:0] idx;
    ns  = (hp >= ht) ? 0 : int'(hp) + 1;
    own = OWN_IDLE;
    idx = 3'd0;
    if (ns inside {1, 3, 5, 7}) begin
      own = OWN_REF;
    end else if (ns inside {9, 11, 13}) begin
      if (r.dsk) own = OWN_DSK;
    end else if (ns inside {15, 17, 19, 21}) begin
      idx = 3'((ns - 15) / 2);
      if (r.aud[idx[1:0]]) own = OWN_AUD;
    end else if (ns >= 23 && ns <= 53 && ns % 2 == 1) begin
      idx = 3'((ns - 23) / 4);
      if (r.spr[idx]) own = OWN_SPR;
    end
    if (own == OWN_IDLE) begin
      if (r.bpl)                                  own = OWN_BPL;
      else if (r.cop && ns % 2 == 0)              own = OWN_COP;
      else if (!r.nasty && cnt >= 3 && r.cpu)     own = OWN_CPU;
      else if (r.blt)                             own = OWN_BLT;
      else if (r.cpu)                             own = OWN_CPU;
    end
    return {own, idx};
  endfunction

  task automatic check_own(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s owner actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s grants actual=%05h required=%05h", nm, act, exp);
    end
  endtask

  task automatic drive(input req_t r);
    bus.req_dsk   = r.dsk;
    bus.req_aud   = r.aud;
    bus.req_spr   = r.spr;
    bus.req_bpl   = r.bpl;
    bus.req_cop   = r.cop;
    bus.req_blt   = r.blt;
    bus.req_cpu   = r.cpu;
    bus.blt_nasty = r.nasty;
  endtask

  task automatic dec_edge(input logic [7:0] hp, input logic [7:0] ht, input req_t r,
                          input logic [3:0] eo, input logic [2:0] ei, input string nm);
    @(negedge clk);
    bus.hpos   = hp;
    bus.htotal = ht;
    drive(r);
    bus.cck    = 1'b1;
    @(posedge clk);
    #1;
    exp_vec_q = mk_vec(eo, ei);
    check_own(nm, bus.owner, eo);
    check_vec(nm, gv, exp_vec_q);
  endtask

  // Second half of the slot: requests dropped, grant must not be revoked.
  task automatic hold_half(input string nm);
    @(negedge clk);
    bus.cck = 1'b0;
    drive('0);
    @(posedge clk);
    #1;
    check_vec({nm, "/hold"}, gv, exp_vec_q);
  endtask

  task automatic model_dec(input logic [7:0] hp, input logic [7:0] ht, input req_t r);
    logic [6:0] m;
    m = model(hp, ht, r, m_cnt);
    if (r.nasty || !r.cpu || m[6:3] == OWN_CPU) m_cnt = 0;
    else if (m[6:3] == OWN_BLT)                 m_cnt++;
    dec_edge(hp, ht, r, m[6:3], m[2:0], "rand");
    hold_half("rand");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.cck = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    check_own("reset", bus.owner, OWN_IDLE);
    check_vec("reset", gv, 18'd0);
    @(negedge clk);
    reset     = 1'b0;
    exp_vec_q = '0;
    m_cnt     = 0;
  endtask

  initial begin
    req_t bc;
    req_t r;
    logic [7:0] hp;
    logic [7:0] ht;
    checks    = 0;
    failures  = 0;
    m_cnt     = 0;
    exp_vec_q = '0;
    reset     = 1'b1;
    bus.cck   = 1'b0;
    bus.hpos  = 8'h00;
    bus.htotal = 8'hE2;
    drive('0);

    tbl[0]  = '{8'h02, 8'hE2, mkreq(1, 4'hF, 8'hFF, 1, 1, 1, 1, 0), OWN_REF,  3'd0};
    tbl[1]  = '{8'h0E, 8'hE2, mkreq(0, 4'b0100, 8'h00, 0, 0, 0, 1, 0), OWN_CPU, 3'd0};
    tbl[2]  = '{8'h12, 8'hE2, mkreq(0, 4'b0100, 8'h00, 0, 0, 0, 0, 0), OWN_AUD, 3'd2};
    tbl[3]  = '{8'h14, 8'hE2, mkreq(0, 4'b1000, 8'h00, 0, 0, 0, 0, 0), OWN_AUD, 3'd3};
    tbl[4]  = '{8'hE2, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 1, 0, 0, 0), OWN_COP,  3'd0};
    tbl[5]  = '{8'h00, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 1, 0, 0, 0), OWN_REF,  3'd0};
    tbl[6]  = '{8'h1F, 8'hE2, mkreq(0, 4'h0, 8'h00, 1, 1, 0, 1, 0), OWN_BPL,  3'd0};
    tbl[7]  = '{8'h1F, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 1, 0, 1, 0), OWN_COP,  3'd0};
    tbl[8]  = '{8'h20, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 1, 0, 1, 0), OWN_CPU,  3'd0};
    tbl[9]  = '{8'h08, 8'hE2, mkreq(1, 4'h0, 8'h00, 0, 0, 0, 0, 0), OWN_DSK,  3'd0};
    tbl[10] = '{8'h0C, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 0, 1, 0, 0), OWN_BLT,  3'd0};
    tbl[11] = '{8'h34, 8'hE2, mkreq(0, 4'h0, 8'h80, 0, 0, 0, 0, 0), OWN_SPR,  3'd7};
    tbl[12] = '{8'h16, 8'hE2, mkreq(0, 4'h0, 8'h01, 0, 0, 0, 0, 0), OWN_SPR,  3'd0};
    tbl[13] = '{8'h1A, 8'hE2, mkreq(0, 4'h0, 8'h01, 0, 0, 1, 0, 0), OWN_BLT,  3'd0};
    tbl[14] = '{8'hF0, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 1, 0, 0, 0), OWN_COP,  3'd0};
    tbl[15] = '{8'h06, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 0, 0, 0, 0), OWN_REF,  3'd0};
    tbl[16] = '{8'h40, 8'hE2, mkreq(0, 4'h0, 8'h00, 0, 0, 0, 0, 0), OWN_IDLE, 3'd0};
    tbl[17] = '{8'h36, 8'hE2, mkreq(0, 4'h0, 8'hFF, 0, 0, 0, 0, 0), OWN_IDLE, 3'd0};
    tbl[18] = '{8'h15, 8'hE2, mkreq(0, 4'h0, 8'hFF, 0, 0, 0, 0, 0), OWN_IDLE, 3'd0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      dec_edge(tbl[i].hp, tbl[i].ht, tbl[i].r, tbl[i].own, tbl[i].idx, $sformatf("tbl%0d", i));
      hold_half($sformatf("tbl%0d", i));
    end

    // Nice mode: three blitter slots, then the waiting CPU; nasty mode: blitter only.
    do_reset();
    bc = mkreq(0, 4'h0, 8'h00, 0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      dec_edge(8'h3F + 8'(i), 8'hE2, bc, (i % 4 == 3) ? OWN_CPU : OWN_BLT, 3'd0, $sformatf("nice%0d", i));
      hold_half("nice");
    end
    r = mkreq(0, 4'h0, 8'h00, 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      dec_edge(8'h4F + 8'(i), 8'hE2, r, OWN_BLT, 3'd0, $sformatf("nasty%0d", i));
      hold_half("nasty");
    end

    // Reset mid-slot while the blitter holds the bus, with the starve count already at its limit.
    do_reset();
    dec_edge(8'h50, 8'hE2, bc, OWN_BLT, 3'd0, "pre_rst0");
    hold_half("pre_rst0");
    dec_edge(8'h51, 8'hE2, bc, OWN_BLT, 3'd0, "pre_rst1");
    hold_half("pre_rst1");
    dec_edge(8'h52, 8'hE2, bc, OWN_BLT, 3'd0, "pre_rst2");
    @(negedge clk);
    bus.cck = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    check_own("mid_rst", bus.owner, OWN_IDLE);
    check_vec("mid_rst", gv, 18'd0);
    @(negedge clk);
    reset     = 1'b0;
    exp_vec_q = '0;
    drive(bc);
    @(posedge clk);
    #1;
    check_vec("mid_rst_wait", gv, 18'd0);
    for (int i = 0; i < 4; i++) begin
      dec_edge(8'h60 + 8'(i), 8'hE2, bc, (i == 3) ? OWN_CPU : OWN_BLT, 3'd0, $sformatf("post_rst%0d", i));
      hold_half("post_rst");
    end

    // Reset beats a simultaneous decision edge.
    @(negedge clk);
    reset    = 1'b1;
    bus.cck  = 1'b1;
    bus.hpos = 8'h70;
    drive(mkreq(1, 4'hF, 8'hFF, 1, 1, 1, 1, 0));
    @(posedge clk);
    #1;
    check_own("rst_vs_cck", bus.owner, OWN_IDLE);
    check_vec("rst_vs_cck", gv, 18'd0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      hp = 8'($urandom_range(0, 255));
      ht = ($urandom_range(0, 3) != 0) ? 8'hE2 : 8'($urandom_range(32, 226));
      r  = mkreq(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
      model_dec(hp, ht, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
